// File: rtl/window_gen_5x5_if.sv
// window_gen_5x5_if: pixel-stream and window bus for window_gen_5x5.
// WINDOW_COORD_EN adds the window centre coordinates.
interface window_gen_5x5_if;
  logic [7:0]   pixel_in;
  logic         pixel_valid;
  logic         sof;
  logic [199:0] image_out;
  logic         window_valid;
  logic         frame_done;
`ifdef WINDOW_COORD_EN
  logic [15:0]  center_row;
  logic [15:0]  center_col;
`endif
  modport master(
    output pixel_in, pixel_valid, sof,
`ifdef WINDOW_COORD_EN
    input center_row, center_col,
`endif
    input image_out, window_valid, frame_done
  );
  modport slave(
    input pixel_in, pixel_valid, sof,
`ifdef WINDOW_COORD_EN
    output center_row, center_col,
`endif
    output image_out, window_valid, frame_done
  );
endinterface

// File: rtl/window_gen_5x5.sv
// window_gen_5x5: raster pixel stream to 5x5 windows via 4 line buffers; WINDOW_COORD_EN adds centre coordinates.
module window_gen_5x5 #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input logic clk,
  input logic rst,
  window_gen_5x5_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  typedef enum logic {FILL, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_col, w_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row, w_row_nxt;
  logic w_acc, w_last_col, w_last_row, w_win_ok;
  logic [7:0] r_lb [4][IMG_WIDTH];
  logic [7:0] r_win [5][5];
  logic [7:0] w_newcol [5];
  logic r_valid, r_done;
  assign w_acc = bus.pixel_valid;
  assign w_col = bus.sof ? '0 : r_col;
  assign w_row = bus.sof ? '0 : r_row;
  assign w_last_col = w_col == CW'(IMG_WIDTH - 1);
  assign w_last_row = w_row == RW'(IMG_HEIGHT - 1);
  // RUN tracks row>=4; columns below 4 would straddle a line wrap
  assign w_win_ok = w_acc && r_state == RUN && !bus.sof && w_col >= CW'(4);
  always_comb begin
    w_col_nxt = w_last_col ? '0 : w_col + 1'b1;
    w_row_nxt = !w_last_col ? w_row : w_last_row ? '0 : w_row + 1'b1;
    w_state_nxt = !w_acc ? r_state
                : (w_last_col && w_row == RW'(3)) ? RUN
                : (bus.sof || (w_last_col && w_last_row)) ? FILL
                : r_state;
    for (int k = 0; k < 4; k++) w_newcol[k] = r_lb[3-k][w_col];
    w_newcol[4] = bus.pixel_in;
  end
  always_ff @(posedge clk) begin
    if (w_acc && !rst) begin
      r_lb[0][w_col] <= bus.pixel_in;
      for (int k = 1; k < 4; k++) r_lb[k][w_col] <= r_lb[k-1][w_col];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) r_win[i][j] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_win_ok;
      r_done  <= w_acc && w_last_row && w_last_col;
      if (w_acc) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 4; j++) r_win[i][j] <= r_win[i][j+1];
          r_win[i][4] <= w_newcol[i];
        end
      end
    end
  end
  for (genvar i = 0; i < 5; i++) begin : g_row
    for (genvar j = 0; j < 5; j++) begin : g_col
      assign bus.image_out[8*(i*5+j) +: 8] = r_win[i][j];
    end
  end
  assign bus.window_valid = r_valid;
  assign bus.frame_done   = r_done;
`ifdef WINDOW_COORD_EN
  logic [15:0] r_crow, r_ccol;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crow <= '0;
      r_ccol <= '0;
    end else if (w_win_ok) begin
      r_crow <= 16'(w_row) - 16'd2;
      r_ccol <= 16'(w_col) - 16'd2;
    end
  end
  assign bus.center_row = r_crow;
  assign bus.center_col = r_ccol;
`endif
endmodule

// File: tb/tb_window_gen_5x5.sv
// tb_window_gen_5x5: table-driven check of window_gen_5x5 on an 8x6 frame.
module tb_window_gen_5x5;
  localparam int W = 8;
  localparam int H = 6;
  typedef struct {
    logic         rst, pv, sof;
    logic [7:0]   pix;
    logic         wv, fd, chk_img;
    logic [199:0] img;
    logic [15:0]  cr, cc;
  } vec_t;
  vec_t vecs[$];
  int n_chk = 0;
  int n_pass = 0;
  logic clk = 1'b0;
  logic rst;
  window_gen_5x5_if bus();
  window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [199:0] win_of(int base, int r, int c);
    logic [199:0] v = '0;
    for (int k = 0; k < 25; k++) v[8*k +: 8] = 8'(base + (r - 4 + k / 5) * 16 + (c - 4 + k % 5));
    return v;
  endfunction

  function automatic void add_px(int base, int r, int c, logic s);
    vec_t v;
    v.rst = 1'b0; v.pv = 1'b1; v.sof = s;
    v.pix = 8'(base + r * 16 + c);
    v.wv = r >= 4 && c >= 4 && !s;
    v.fd = r == H - 1 && c == W - 1;
    v.chk_img = v.wv;
    v.img = v.wv ? win_of(base, r, c) : '0;
    v.cr = 16'(r - 2); v.cc = 16'(c - 2);
    vecs.push_back(v);
  endfunction

  function automatic void add_idle();
    vec_t v;
    v.rst = 1'b0; v.pv = 1'b0; v.sof = 1'b0; v.pix = 8'hEE;
    v.wv = 1'b0; v.fd = 1'b0; v.chk_img = 1'b0; v.img = '0; v.cr = '0; v.cc = '0;
    vecs.push_back(v);
  endfunction

  function automatic void add_rst(logic pv);
    vec_t v;
    v.rst = 1'b1; v.pv = pv; v.sof = pv; v.pix = 8'h55;
    v.wv = 1'b0; v.fd = 1'b0; v.chk_img = 1'b1; v.img = '0; v.cr = '0; v.cc = '0;
    vecs.push_back(v);
  endfunction

  function automatic void add_range(int base, int p0, int p1, logic sof_first, logic idle);
    for (int p = p0; p < p1; p++) begin
      add_px(base, p / W, p % W, sof_first && p == p0);
      if (idle) add_idle();
    end
  endfunction

  task automatic chk(string name, int idx, logic [199:0] act, logic [199:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %0h want %0h", name, idx, act, exp);
  endtask

  task automatic run_range(input int lo, input int hi, output int nwin,
                           output logic [7:0] f12, output logic [7:0] l12, output logic fdl);
    bit seen = 0;
    nwin = 0; f12 = '0; l12 = '0; fdl = 1'b0;
    for (int i = lo; i < hi; i++) begin
      rst = vecs[i].rst;
      bus.pixel_valid = vecs[i].pv;
      bus.sof = vecs[i].sof;
      bus.pixel_in = vecs[i].pix;
      @(posedge clk);
      #1;
      chk("window_valid", i, 200'(bus.window_valid), 200'(vecs[i].wv));
      chk("frame_done", i, 200'(bus.frame_done), 200'(vecs[i].fd));
      if (vecs[i].chk_img) chk("image_out", i, bus.image_out, vecs[i].img);
`ifdef WINDOW_COORD_EN
      if (vecs[i].wv) begin
        chk("center_row", i, 200'(bus.center_row), 200'(vecs[i].cr));
        chk("center_col", i, 200'(bus.center_col), 200'(vecs[i].cc));
      end
`endif
      if (bus.window_valid === 1'b1) begin
        nwin++;
        if (!seen) f12 = bus.image_out[103:96];
        seen = 1;
        l12 = bus.image_out[103:96];
        fdl = bus.frame_done;
      end
    end
  endtask

  initial begin
    int m[12];
    int nw;
    logic [7:0] f, l;
    logic fd;
    rst = 1'b1; bus.pixel_valid = 1'b0; bus.sof = 1'b0; bus.pixel_in = '0;
    m[0] = vecs.size(); add_rst(1'b0); add_rst(1'b0);
    m[1] = vecs.size(); add_range(0, 0, W * H, 1'b0, 1'b0);
    m[2] = vecs.size(); add_range(0, 0, W * H, 1'b0, 1'b1);
    m[3] = vecs.size(); add_range(0, 0, W * H, 1'b0, 1'b0);
    m[4] = vecs.size(); add_range(8'h80, 0, W * H, 1'b0, 1'b0);
    m[5] = vecs.size(); add_range(8'h40, 0, 3 * W + 4, 1'b0, 1'b0); add_rst(1'b1); add_rst(1'b0);
    m[6] = vecs.size(); add_range(0, 0, W * H, 1'b0, 1'b0);
    m[7] = vecs.size(); add_range(8'h40, 0, 2 * W + 5, 1'b0, 1'b0); add_range(0, 0, W * H, 1'b1, 1'b0);
    m[8] = vecs.size();
    run_range(m[0], m[1], nw, f, l, fd);
    chk("reset_no_windows", m[0], 200'(nw), 200'(0));
    run_range(m[1], m[2], nw, f, l, fd);
    chk("c1_count", m[1], 200'(nw), 200'(8));
    chk("c1_first_b12", m[1], 200'(f), 200'(8'h22));
    chk("c1_last_b12", m[1], 200'(l), 200'(8'h35));
    chk("c1_last_done", m[1], 200'(fd), 200'(1));
    run_range(m[2], m[3], nw, f, l, fd);
    chk("c2_count", m[2], 200'(nw), 200'(8));
    chk("c2_first_b12", m[2], 200'(f), 200'(8'h22));
    chk("c2_last_b12", m[2], 200'(l), 200'(8'h35));
    run_range(m[3], m[4], nw, f, l, fd);
    chk("c3_f1_count", m[3], 200'(nw), 200'(8));
    run_range(m[4], m[5], nw, f, l, fd);
    chk("c3_f2_count", m[4], 200'(nw), 200'(8));
    chk("c3_f2_first_b12", m[4], 200'(f), 200'(8'hA2));
    chk("c3_f2_last_b12", m[4], 200'(l), 200'(8'hB5));
    run_range(m[5], m[6], nw, f, l, fd);
    chk("c4_abort_count", m[5], 200'(nw), 200'(0));
    run_range(m[6], m[7], nw, f, l, fd);
    chk("c4_count", m[6], 200'(nw), 200'(8));
    chk("c4_first_b12", m[6], 200'(f), 200'(8'h22));
    run_range(m[7], m[8], nw, f, l, fd);
    chk("c5_count", m[7], 200'(nw), 200'(8));
    chk("c5_first_b12", m[7], 200'(f), 200'(8'h22));
    chk("c5_last_b12", m[7], 200'(l), 200'(8'h35));
    chk("c5_last_done", m[7], 200'(fd), 200'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/window_gen_5x5.md
Name: window_gen_5x5

Overview:
- Raster-scan pixel stream in, 5x5 neighbourhood windows out, one per interior pixel.
- Output bus uses the 200-bit packed window format consumed by the 5x5 edge/filter kernels, so it drives those kernels directly.
- Holds 4 line buffers plus a 5x5 register window. Frame geometry is fixed by parameters.

Parameters:
- IMG_WIDTH, 64: pixels per line; must be >= 5.
- IMG_HEIGHT, 64: lines per frame; must be >= 5.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pixel_in  in  8  input pixel, unsigned.
- pixel_valid  in  1  pixel_in is accepted this cycle. No backpressure.
- sof  in  1  start of frame; qualified by pixel_valid; forces that pixel to position (0,0).
- image_out  out  200  5x5 window. Byte k = image_out[8k+7:8k], k = row*5+col. Row 0 = oldest line (top), col 0 = oldest pixel (left), byte 12 = centre.
- window_valid  out  1  image_out holds a complete in-frame window this cycle.
- frame_done  out  1  one-cycle pulse, coincident with the window of the last pixel of the frame.

Behaviour:
- Decided interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: image_out=0, window_valid=0, frame_done=0; col/row counters=0; state=FILL. Line-buffer RAM is not cleared.
- Counters:
  - col 0..IMG_WIDTH-1; row 0..IMG_HEIGHT-1.
  - Both advance only on an accepted pixel (pixel_valid=1); col wraps to 0 and increments row.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 (next frame).
  - Idle cycles (pixel_valid=0) hold all state; window_valid=0.
- sof=1 with pixel_valid=1: the pixel is treated as (0,0) regardless of counters; counters proceed from there.
- Line buffers L1..L4, each IMG_WIDTH x 8. Lk[c] holds the pixel at column c, k lines above the current one.
- On accept at (r,c):
  - New column, top to bottom = {L4[c], L3[c], L2[c], L1[c], pixel_in}.
  - Window shifts left one column; the new column enters col 4.
  - Then L4[c]<=L3[c], L3[c]<=L2[c], L2[c]<=L1[c], L1[c]<=pixel_in.
- Output timing:
  - image_out and window_valid are registered, 1 cycle after the accept.
  - window_valid=1 iff the accepted pixel had r>=4 and c>=4; the window centre is then (r-2, c-2).
  - Windows at c<4 span a line wrap and are suppressed.
- Window count: (IMG_WIDTH-4)*(IMG_HEIGHT-4) valid windows per frame; no border windows are produced.
- State machine (informational, for debug):
  - FILL: row<4.
  - RUN: row>=4.
  - FILL->RUN on accept of (3, IMG_WIDTH-1).
  - RUN->FILL on frame wrap or sof.
- frame_done: registered 1 on the cycle after accepting (IMG_HEIGHT-1, IMG_WIDTH-1); otherwise 0.
- Reset mid-frame:
  - Counters go to 0 and outputs to 0 on the next edge.
  - Stale line-buffer data never reaches a valid window, because rows 0-3 rewrite every line entry before row 4.
- sof mid-frame: same as reset for counters and state. The current pixel is still written to L1[0]; window_valid=0 for that pixel.
- rst has priority over pixel_valid/sof in the same cycle.

Optional Feature:
- Macro: WINDOW_COORD_EN.
- Defined: adds outputs center_row [15:0] and center_col [15:0].
  - Registered alongside image_out; equal to (r-2, c-2) when window_valid=1.
  - Hold their last value otherwise; reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=6, continuous stream, pixel=r*16+c -> first window_valid 1 cycle after pixel (4,4) accepted; byte k = (k/5)*16 + k%5; byte 12 = 0x22; exactly 8 valid windows per frame; last window byte 12 = 0x35, with frame_done=1 in the same cycle.
- Same stream with pixel_valid deasserted every other cycle -> identical window sequence; window_valid never high on idle-following cycles without an accept.
- Two back-to-back frames, frame 2 pixels = r*16+c+0x80 -> frame 2 first window byte 12 = 0xA2; no window mixes frame-1 data after row 4 of frame 2.
- rst asserted mid-row 3 of a frame, then a fresh frame -> no window_valid until pixel (4,4) of the new frame; window contents match case 1.
- sof asserted at stream position (2,5) with a new frame following -> counters resync; first valid window byte 12 = 0x22 relative to the new frame.
- WINDOW_COORD_EN defined, case 1 stimulus -> first window center_row=2, center_col=2; last window center_row=3, center_col=5.
